// File: rtl/dct2d_ctrl.sv
// 8x8 2D forward DCT sequencer: row pass -> 8x8 transpose buffer -> column pass on one shared DCT1D core.
// First coefficient 18 cycles after the first row; in_ready low while a block is in flight, no output backpressure.
module dct2d_ctrl #(
    parameter int PIX_W = 9,
    parameter int CW    = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*PIX_W-1:0]   in_pix,
    output logic                 dct_valid,
    output logic [8*CW-1:0]      dct_x,
    input  logic                 dct_ready,
    input  logic [8*CW-1:0]      dct_z,
    output logic                 out_valid,
    output logic [2:0]           out_col,
    output logic                 out_last,
    output logic [8*CW-1:0]      out_coef,
    output logic                 busy
);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        ROW_WAIT  = 2'd1,
        COL_ISSUE = 2'd2,
        COL_WAIT  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2:0]      r_in_cnt;
    logic [2:0]      r_res_cnt;
    logic [2:0]      r_col_cnt;
    logic [2:0]      r_out_cnt;

    logic            r_dct_valid;
    logic [8*CW-1:0] r_dct_x;
    logic            r_out_valid;
    logic [2:0]      r_out_col;
    logic            r_out_last;
    logic [8*CW-1:0] r_out_coef;

    // Transpose buffer, indexed [row][column].
    logic [CW-1:0]   r_buf [8][8];

    logic            w_accept;
    logic            w_row_res;
    logic            w_col_res;
    logic            w_issue;
    logic [8*CW-1:0] w_issue_dat;
    logic [8*CW-1:0] w_pix_ext;
    logic [8*CW-1:0] w_col_dat;

    assign in_ready = (r_state == LOAD);
    assign w_accept = in_valid && in_ready;

    // In idle LOAD (both counters zero) a core result cannot belong to any block.
    assign w_row_res = dct_ready &&
                       (((r_state == LOAD) && ((r_in_cnt != 3'd0) || (r_res_cnt != 3'd0))) ||
                        (r_state == ROW_WAIT));
    assign w_col_res = dct_ready && ((r_state == COL_ISSUE) || (r_state == COL_WAIT));

    always_comb begin
        w_pix_ext = '0;
        w_col_dat = '0;
        for (int k = 0; k < 8; k++) begin
            w_pix_ext[k*CW +: CW] = {{(CW-PIX_W){in_pix[k*PIX_W+PIX_W-1]}}, in_pix[k*PIX_W +: PIX_W]};
            w_col_dat[k*CW +: CW] = r_buf[k][r_col_cnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_dat = w_pix_ext;
        case (r_state)
            LOAD: begin
                w_issue = w_accept;
                if (w_accept && (r_in_cnt == 3'd7)) begin
                    w_state_nxt = ROW_WAIT;
                end
            end
            ROW_WAIT: begin
                if (w_row_res && (r_res_cnt == 3'd7)) begin
                    w_state_nxt = COL_ISSUE;
                end
            end
            COL_ISSUE: begin
                w_issue     = 1'b1;
                w_issue_dat = w_col_dat;
                if (r_col_cnt == 3'd7) begin
                    w_state_nxt = COL_WAIT;
                end
            end
            COL_WAIT: begin
                if (w_col_res && (r_out_cnt == 3'd7)) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= 3'd0;
            r_res_cnt <= 3'd0;
            r_col_cnt <= 3'd0;
            r_out_cnt <= 3'd0;
        end else begin
            if (w_accept) begin
                r_in_cnt <= r_in_cnt + 3'd1;
            end
            if (w_row_res) begin
                r_res_cnt <= r_res_cnt + 3'd1;
            end
            if (r_state == COL_ISSUE) begin
                r_col_cnt <= r_col_cnt + 3'd1;
            end
            if (w_col_res) begin
                r_out_cnt <= r_out_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dct_valid <= 1'b0;
            r_dct_x     <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= 3'd0;
            r_out_last  <= 1'b0;
            r_out_coef  <= '0;
        end else begin
            r_dct_valid <= w_issue;
            if (w_issue) begin
                r_dct_x <= w_issue_dat;
            end
            r_out_valid <= w_col_res;
            if (w_col_res) begin
                r_out_coef <= dct_z;
                r_out_col  <= r_out_cnt;
                r_out_last <= (r_out_cnt == 3'd7);
            end
        end
    end

    // Every entry is rewritten by the row pass before the column pass reads it.
    always_ff @(posedge clk) begin
        if (w_row_res) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[r_res_cnt][k] <= dct_z[k*CW +: CW];
            end
        end
    end

    assign dct_valid = r_dct_valid;
    assign dct_x     = r_dct_x;
    assign out_valid = r_out_valid;
    assign out_col   = r_out_col;
    assign out_last  = r_out_last;
    assign out_coef  = r_out_coef;
    assign busy      = (r_state != LOAD) || (r_in_cnt != 3'd0);

endmodule
